// File: rtl/run_tx_pkg.sv
// Shared types and constants for the run_tx burst transmitter.
package run_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP,
        DONE
    } state_e;

    localparam int unsigned DEF_LEN_W = 8;
    localparam int unsigned DEF_REP_W = 4;
    localparam int unsigned MIN_GAP   = 1;

endpackage

// File: rtl/run_tx_if.sv
// Command/status bundle between a run_tx user (master) and the transmitter (slave).
interface run_tx_if #(
    parameter int unsigned LEN_W = run_tx_pkg::DEF_LEN_W,
    parameter int unsigned REP_W = run_tx_pkg::DEF_REP_W
);
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] run_len;
    logic [LEN_W-1:0] gap_len;
    logic [REP_W-1:0] reps;
    logic             w;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] bursts_sent;

    modport master (
        output start, abort, run_len, gap_len, reps,
        input  w, busy, done, bursts_sent
    );

    modport slave (
        input  start, abort, run_len, gap_len, reps,
        output w, busy, done, bursts_sent
    );
endinterface

// File: rtl/run_tx_down_counter.sv
// Loadable down counter that stops at zero and flags when it holds exactly one.
module run_tx_down_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             is_one_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_one_o = (cnt_q == WIDTH'(1));
endmodule

// File: rtl/run_tx.sv
// Burst transmitter: drives w high for run_len cycles, low for max(gap_len,1), reps times.
module run_tx
    import run_tx_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W,
    parameter int unsigned REP_W = DEF_REP_W
) (
    input logic     clk,
    input logic     reset,
    run_tx_if.slave bus
);
    state_e           state_q, state_d;
    logic [LEN_W-1:0] run_len_q, run_len_d;
    logic [LEN_W-1:0] gap_len_q, gap_len_d;
    logic [REP_W-1:0] bursts_q, bursts_d;

    logic             cnt_load, cnt_en, cnt_is_one;
    logic [LEN_W-1:0] cnt_val;
    logic             rem_load, rem_en, rem_is_one;
    logic [LEN_W-1:0] gap_eff;

    // A zero gap would merge consecutive bursts on the line.
    assign gap_eff = (gap_len_q == '0) ? LEN_W'(MIN_GAP) : gap_len_q;

    run_tx_down_counter #(.WIDTH(LEN_W)) u_phase_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (cnt_en),
        .is_one_o   (cnt_is_one)
    );

    run_tx_down_counter #(.WIDTH(REP_W)) u_rem_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (rem_load),
        .load_val_i (bus.reps),
        .en_i       (rem_en),
        .is_one_o   (rem_is_one)
    );

    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        gap_len_d = gap_len_q;
        bursts_d  = bursts_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_en    = 1'b0;
        rem_load  = 1'b0;
        rem_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    run_len_d = bus.run_len;
                    gap_len_d = bus.gap_len;
                    bursts_d  = '0;
                    if ((bus.run_len == '0) || (bus.reps == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d  = RUN;
                        cnt_load = 1'b1;
                        cnt_val  = bus.run_len;
                        rem_load = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_is_one) begin
                    bursts_d = bursts_q + REP_W'(1);
                    rem_en   = 1'b1;
                    if (rem_is_one) begin
                        state_d = DONE;
                    end else begin
                        state_d  = GAP;
                        cnt_load = 1'b1;
                        cnt_val  = gap_eff;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            GAP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_is_one) begin
                    state_d  = RUN;
                    cnt_load = 1'b1;
                    cnt_val  = run_len_q;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            run_len_q <= '0;
            gap_len_q <= '0;
            bursts_q  <= '0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
            gap_len_q <= gap_len_d;
            bursts_q  <= bursts_d;
        end
    end

    assign bus.w           = (state_q == RUN);
    assign bus.busy        = (state_q == RUN) || (state_q == GAP);
    assign bus.done        = (state_q == DONE);
    assign bus.bursts_sent = bursts_q;
endmodule

// File: tb/tb_run_tx.sv
// Directed and randomized checks of run_tx against a per-cycle waveform model.
module tb_run_tx;
    localparam int unsigned LW = 8;
    localparam int unsigned RW = 4;

    typedef struct {
        logic          w;
        logic          busy;
        logic          done;
        logic [RW-1:0] bs;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    run_tx_if #(.LEN_W(LW), .REP_W(RW)) bus ();

    run_tx #(.LEN_W(LW), .REP_W(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    obs_t        exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input obs_t e);
        chk({tag, ".w"},    32'(bus.w),           32'(e.w));
        chk({tag, ".busy"}, 32'(bus.busy),        32'(e.busy));
        chk({tag, ".done"}, 32'(bus.done),        32'(e.done));
        chk({tag, ".bs"},   32'(bus.bursts_sent), 32'(e.bs));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line waveform: reps bursts of run_len highs separated by max(gap,1) lows, then DONE.
    task automatic build(input int rl, input int gl, input int rp);
        int g;
        exp_q.delete();
        g = (gl == 0) ? 1 : gl;
        if (rl == 0 || rp == 0) begin
            exp_q.push_back('{1'b0, 1'b0, 1'b1, RW'(0)});
        end else begin
            for (int r = 1; r <= rp; r++) begin
                for (int i = 0; i < rl; i++) exp_q.push_back('{1'b1, 1'b1, 1'b0, RW'(r - 1)});
                if (r < rp)
                    for (int i = 0; i < g; i++) exp_q.push_back('{1'b0, 1'b1, 1'b0, RW'(r)});
            end
            exp_q.push_back('{1'b0, 1'b0, 1'b1, RW'(rp)});
        end
    endtask

    task automatic run_transfer(input int rl, input int gl, input int rp, input bit noise, input string tag);
        obs_t last;
        build(rl, gl, rp);
        bus.start   = 1'b1;
        bus.run_len = LW'(rl);
        bus.gap_len = LW'(gl);
        bus.reps    = RW'(rp);
        tick();
        bus.start = 1'b0;
        foreach (exp_q[i]) begin
            chk_all($sformatf("%s.c%0d", tag, i + 1), exp_q[i]);
            if (noise && !exp_q[i].done) begin
                bus.start   = 1'($urandom_range(0, 1));
                bus.run_len = LW'($urandom);
                bus.gap_len = LW'($urandom);
                bus.reps    = RW'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        last = exp_q[exp_q.size() - 1];
        chk_all({tag, ".idle"}, '{1'b0, 1'b0, 1'b0, last.bs});
    endtask

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.run_len = '0;
        bus.gap_len = '0;
        bus.reps    = '0;
        tick();
        chk_all("rst0", '{1'b0, 1'b0, 1'b0, RW'(0)});
        tick();
        chk_all("rst1", '{1'b0, 1'b0, 1'b0, RW'(0)});
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("idle%0d", i), '{1'b0, 1'b0, 1'b0, RW'(0)});
        end

        run_transfer(3, 2, 2, 1'b0, "t322");
        run_transfer(1, 0, 3, 1'b0, "t103");
        run_transfer(0, 4, 5, 1'b0, "t0len");
        run_transfer(5, 1, 0, 1'b0, "t0rep");

        // abort on the second GAP cycle of the first gap
        bus.start = 1'b1; bus.run_len = 8'd4; bus.gap_len = 8'd3; bus.reps = 4'd3;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_all("ab.gap2", '{1'b0, 1'b1, 1'b0, RW'(1)});
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk_all("ab.idle", '{1'b0, 1'b0, 1'b0, RW'(1)});
        tick();
        chk_all("ab.nodone", '{1'b0, 1'b0, 1'b0, RW'(1)});

        // same point, reset instead of abort
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_all("rs.gap2", '{1'b0, 1'b1, 1'b0, RW'(1)});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all("rs.idle", '{1'b0, 1'b0, 1'b0, RW'(0)});
        tick();
        chk_all("rs.nodone", '{1'b0, 1'b0, 1'b0, RW'(0)});

        // start held high: DONE ignores it, IDLE accepts it
        bus.start = 1'b1; bus.run_len = 8'd2; bus.gap_len = 8'd1; bus.reps = 4'd1;
        tick(); chk_all("hold.c1", '{1'b1, 1'b1, 1'b0, RW'(0)});
        tick(); chk_all("hold.c2", '{1'b1, 1'b1, 1'b0, RW'(0)});
        tick(); chk_all("hold.c3", '{1'b0, 1'b0, 1'b1, RW'(1)});
        tick(); chk_all("hold.c4", '{1'b0, 1'b0, 1'b0, RW'(1)});
        tick(); chk_all("hold.c5", '{1'b1, 1'b1, 1'b0, RW'(0)});
        bus.start = 1'b0;
        tick(); chk_all("hold.c6", '{1'b1, 1'b1, 1'b0, RW'(0)});
        tick(); chk_all("hold.c7", '{1'b0, 1'b0, 1'b1, RW'(1)});
        tick(); chk_all("hold.c8", '{1'b0, 1'b0, 1'b0, RW'(1)});

        // abort while idle has no effect
        bus.abort = 1'b1;
        tick(); chk_all("ab.inidle", '{1'b0, 1'b0, 1'b0, RW'(1)});
        bus.abort = 1'b0;

        for (int k = 0; k < 12; k++) begin
            run_transfer(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                         int'($urandom_range(0, 4)), 1'b1, $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
